// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the GPR writeback arbiter slice.
//   REQ_EXU / REQ_LSU : requester indices into the 2-bit request/grant vectors
//   last_win_e        : round-robin pointer value (which requester won last)
//   wb_req_t          : writeback record {rd, wd} for the default RV32I
//                       configuration (32 GPRs, 32-bit data)
package rf_wb_arbiter_pkg;

  localparam bit REQ_EXU = 1'b0;
  localparam bit REQ_LSU = 1'b1;

  localparam int unsigned PKG_NREG = 32;
  localparam int unsigned PKG_XLEN = 32;
  localparam int unsigned PKG_AW   = $clog2(PKG_NREG);

  typedef struct packed {
    logic [PKG_AW-1:0]   rd;
    logic [PKG_XLEN-1:0] wd;
  } wb_req_t;

  typedef enum logic {
    LAST_EXU = 1'b0,
    LAST_LSU = 1'b1
  } last_win_e;

endpackage

// File: rtl/rf_wb_arbiter_arb.sv
// rr_arb2: two-way arbiter for the GPR write port.
//   clk, rst   : clock, asynchronous active-low reset
//   req[1:0]   : request vector, indexed by REQ_EXU / REQ_LSU
//   gnt[1:0]   : one-hot (or zero) grant, same cycle as req
// With FIXED_PRIO=1, EXU always wins a contention; otherwise the requester
// that did not win last time wins. The pointer follows every grant, so after
// reset (pointer = LSU) EXU is preferred.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  last_win_e last_q, last_d;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (req[REQ_EXU] && req[REQ_LSU]) begin
      if (FIXED_PRIO || (last_q == LAST_LSU)) gnt[REQ_EXU] = 1'b1;
      else                                    gnt[REQ_LSU] = 1'b1;
    end else begin
      gnt = req;
    end
    if (gnt[REQ_EXU])      last_d = LAST_EXU;
    else if (gnt[REQ_LSU]) last_d = LAST_LSU;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= LAST_LSU;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single GPR write port between the EXU and LSU
// writeback paths and keeps a per-register busy scoreboard for issue hazards.
//   clk, rst                    : clock, asynchronous active-low reset
//   iss_valid/rd/rd_en/rs1/rs2  : issuing instruction
//   iss_stall                   : RAW/WAW hazard against the scoreboard
//   exu_valid/rd/wd, exu_ready  : EXU writeback request / acceptance
//   lsu_valid/rd/wd, lsu_ready  : LSU writeback request / acceptance
//   rf_we/rf_rd/rf_wd           : registered write port to the register array
//   busy_vec                    : scoreboard (bit 0 always 0)
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREG       = 32,
  parameter int unsigned XLEN       = 32,
  parameter bit          FIXED_PRIO = 1'b0,
  localparam int unsigned AW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rd_en,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            iss_stall,
  input  logic            exu_valid,
  input  logic [AW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_wd,
  output logic            exu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            lsu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [NREG-1:0] busy_vec
);

  // Writeback record sized to this instance's parameters.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
  } wb_slot_t;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       accept;
  wb_slot_t   win;

  always_comb begin
    req          = '0;
    req[REQ_EXU] = exu_valid;
    req[REQ_LSU] = lsu_valid;
  end

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt)
  );

  assign exu_ready = gnt[REQ_EXU];
  assign lsu_ready = gnt[REQ_LSU];
  assign accept    = |gnt;

  always_comb begin
    if (gnt[REQ_LSU]) win = '{rd: lsu_rd, wd: lsu_wd};
    else              win = '{rd: exu_rd, wd: exu_wd};
  end

  // Output stage: one-cycle latency to the register array. A write to x0 is
  // accepted but never asserts rf_we; rf_rd/rf_wd hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (accept) begin
      rf_we <= (win.rd != '0);
      rf_rd <= win.rd;
      rf_wd <= win.wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Scoreboard.
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            iss_fire;

  always_comb begin
    iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] |
                             (iss_rd_en & busy_q[iss_rd]));
    iss_fire  = iss_valid & ~iss_stall & iss_rd_en;
    set_mask  = '0;
    clr_mask  = '0;
    // Loop starts at 1 so x0 can never become busy.
    for (int unsigned r = 1; r < NREG; r++) begin
      if (iss_fire && (iss_rd == AW'(r))) set_mask[r] = 1'b1;
      if (rf_we && (rf_rd == AW'(r)))     clr_mask[r] = 1'b1;
    end
    // Set applied after clear: a same-cycle reissue keeps the register busy.
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule
